reaction_timer_ctrl: RTL and testbench

//  Sequencer for one reaction-time trial. Generates a pseudo-random 1..4 s

---
 rtl/reaction_timer_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
//==============================================================================
// Module      : reaction_timer_ctrl
// Description : Sequencer for one reaction-time trial. After a start pulse it
//               loads an external 2-bit down-counter with a pseudo-random seed
//               and counts it down once per second. When the counter is at
//               zero on a second tick, the GO lamp lights. The reaction time is
//               then counted in milliseconds until a stop pulse arrives or the
//               count saturates at MAX_MS. Early presses and timeouts are
//               flagged.
// Ports       : clk, reset (sync, active-high)
//               start, stop      - debounced 1-cycle pulses
//               dly_zero         - external delay counter is zero
//               dly_load/dly_data- load external counter with random seed
//               dly_en           - decrement external counter
//               led, busy        - GO lamp, trial in progress
//               result_ms/result_valid/too_early/timeout - trial outcome
//               best_ms          - best valid result (REACTION_BEST_EN only)
// Options     : `define REACTION_BEST_EN adds the best_ms tracker and port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reaction_timer_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int MS_PER_S = 1000,
    parameter int MAX_MS   = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        dly_zero,
    output logic        dly_load,
    output logic [1:0]  dly_data,
    output logic        dly_en,
    output logic        led,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        too_early,
`ifdef REACTION_BEST_EN
    output logic [13:0] best_ms,
`endif
    output logic        timeout
);

    localparam int MS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int S_W  = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;

    localparam logic [MS_W-1:0] c_ms_last = MS_W'(TICK_DIV - 1);
    localparam logic [S_W-1:0]  c_s_last  = S_W'(MS_PER_S - 1);
    localparam logic [13:0]     c_max_ms  = 14'(MAX_MS);
    localparam logic [7:0]      c_lfsr_seed = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_GO   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_q,  state_d;
    logic [7:0]        lfsr_q,   lfsr_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [S_W-1:0]    s_cnt_q,  s_cnt_d;
    logic [13:0]       result_q, result_d;
    logic              valid_q,  valid_d;
    logic              early_q,  early_d;
    logic              tout_q,   tout_d;
`ifdef REACTION_BEST_EN
    logic [13:0]       best_q,   best_d;
`endif

    logic              w_ms_tick;
    logic              w_s_tick;
    logic [13:0]       w_result_inc;

    // Prescalers are held at zero outside WAIT/GO, so the ticks can only
    // fire while they are actually counting.
    assign w_ms_tick    = (ms_cnt_q == c_ms_last);
    assign w_s_tick     = w_ms_tick && (s_cnt_q == c_s_last);
    assign w_result_inc = (result_q == c_max_ms) ? result_q : result_q + 14'd1;

    always_comb begin
        state_d  = state_q;
        // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; free-running, never all-zero.
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        ms_cnt_d = '0;
        s_cnt_d  = '0;
        result_d = result_q;
        valid_d  = valid_q;
        early_d  = early_q;
        tout_d   = tout_q;
`ifdef REACTION_BEST_EN
        best_d   = best_q;
`endif
        dly_en   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_ARM;
                    result_d = '0;
                    valid_d  = 1'b0;
                    early_d  = 1'b0;
                    tout_d   = 1'b0;
                end
            end

            // Prescalers fall to zero through the defaults in this cycle.
            ST_ARM: begin
                if (stop) begin
                    state_d = ST_DONE;
                    early_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                ms_cnt_d = w_ms_tick ? '0 : ms_cnt_q + 1'b1;
                s_cnt_d  = w_ms_tick ? (w_s_tick ? '0 : s_cnt_q + 1'b1) : s_cnt_q;
                if (stop) begin
                    state_d = ST_DONE;
                    early_d = 1'b1;
                end else if (w_s_tick) begin
                    if (dly_zero) begin
                        state_d  = ST_GO;
                        ms_cnt_d = '0;
                        result_d = '0;
                    end else begin
                        dly_en = 1'b1;
                    end
                end
            end

            ST_GO: begin
                ms_cnt_d = w_ms_tick ? '0 : ms_cnt_q + 1'b1;
                if (w_ms_tick) begin
                    result_d = w_result_inc;
                end
                // A stop coincident with the saturating tick still counts as a
                // valid reaction, so stop is tested first.
                if (stop) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
`ifdef REACTION_BEST_EN
                    if (result_d < best_q) begin
                        best_d = result_d;
                    end
`endif
                end else if (w_ms_tick && (w_result_inc == c_max_ms)) begin
                    state_d = ST_DONE;
                    tout_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= c_lfsr_seed;
            ms_cnt_q <= '0;
            s_cnt_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            early_q  <= 1'b0;
            tout_q   <= 1'b0;
`ifdef REACTION_BEST_EN
            best_q   <= 14'h3FFF;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            ms_cnt_q <= ms_cnt_d;
            s_cnt_q  <= s_cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            early_q  <= early_d;
            tout_q   <= tout_d;
`ifdef REACTION_BEST_EN
            best_q   <= best_d;
`endif
        end
    end

    assign dly_load     = (state_q == ST_ARM);
    assign dly_data     = (state_q == ST_ARM) ? lfsr_q[1:0] : 2'b00;
    assign led          = (state_q == ST_GO);
    assign busy         = (state_q == ST_ARM) || (state_q == ST_WAIT) || (state_q == ST_GO);
    assign result_ms    = result_q;
    assign result_valid = valid_q;
    assign too_early    = early_q;
    assign timeout      = tout_q;
`ifdef REACTION_BEST_EN
    assign best_ms      = best_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
//==============================================================================
// Module      : tb_reaction_timer_ctrl
// Description : Self-checking bench for reaction_timer_ctrl. A timeline model
//               (cycles elapsed since ARM) predicts every output each cycle;
//               directed trials add literal expectations on top.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reaction_timer_ctrl;

    localparam int TD    = 4;
    localparam int MPS   = 10;
    localparam int MAXMS = 50;
    localparam int S_CYC = TD * MPS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        dly_zero;
    logic        dly_load;
    logic [1:0]  dly_data;
    logic        dly_en;
    logic        led;
    logic        busy;
    logic [13:0] result_ms;
    logic        result_valid;
    logic        too_early;
    logic        timeout;
`ifdef REACTION_BEST_EN
    logic [13:0] best_ms;
`endif

    reaction_timer_ctrl #(
        .TICK_DIV (TD),
        .MS_PER_S (MPS),
        .MAX_MS   (MAXMS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .dly_zero     (dly_zero),
        .dly_load     (dly_load),
        .dly_data     (dly_data),
        .dly_en       (dly_en),
        .led          (led),
        .busy         (busy),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .too_early    (too_early),
`ifdef REACTION_BEST_EN
        .best_ms      (best_ms),
`endif
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // External 2-bit loadable down-counter
    logic [1:0] dc = 2'd0;
    always @(posedge clk) begin
        if (dly_load)    dc <= dly_data;
        else if (dly_en) dc <= dc - 2'd1;
    end
    assign dly_zero = (dc == 2'd0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // ---------------- timeline model ----------------
    bit         m_init = 1'b0;
    logic [7:0] m_lfsr;
    bit         m_active, nxt_active;
    int         m_el;       // cycles since ARM in the current cycle
    int         m_seed;
    int         m_result;
    bit         m_valid, m_early, m_tout;
    int         m_best;
    int         k;

    function automatic int go_off(input int seed);
        return 1 + (seed + 1) * S_CYC;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1; m_lfsr = 8'hA5; m_active = 1'b0; m_el = 0; m_seed = 0;
            m_result = 0; m_valid = 1'b0; m_early = 1'b0; m_tout = 1'b0; m_best = 16383;
        end else if (m_init) begin
            nxt_active = m_active;
            if (!m_active) begin
                if (start) begin
                    nxt_active = 1'b1; m_el = -1; m_result = 0;
                    m_valid = 1'b0; m_early = 1'b0; m_tout = 1'b0;
                end
            end else if (m_el < go_off(m_seed)) begin
                if (stop) begin nxt_active = 1'b0; m_early = 1'b1; end
            end else begin
                k = m_el - go_off(m_seed);
                if (stop) begin
                    nxt_active = 1'b0; m_result = (k + 1) / TD; m_valid = 1'b1;
                    if (m_result < m_best) m_best = m_result;
                end else if (k + 1 == MAXMS * TD) begin
                    nxt_active = 1'b0; m_result = MAXMS; m_tout = 1'b1;
                end
            end
            m_lfsr = lfsr_step(m_lfsr);
            if (nxt_active && !m_active) m_seed = int'(m_lfsr[1:0]);
            m_active = nxt_active;
            if (m_active) m_el++;
        end
    end

    // ---------------- per-cycle compare ----------------
    int  e_off, e_res;
    bit  e_go, e_load, e_en;
    always @(negedge clk) begin
        if (m_init) begin
            e_off  = go_off(m_seed);
            e_load = m_active && (m_el == 0);
            e_go   = m_active && (m_el >= e_off);
            e_en   = m_active && (m_el >= S_CYC) && (m_el % S_CYC == 0) &&
                     (m_el < e_off - 1) && !stop;
            e_res  = e_go ? (m_el - e_off) / TD : m_result;
            check("busy",         int'(busy),         int'(m_active));
            check("led",          int'(led),          int'(e_go));
            check("dly_load",     int'(dly_load),     int'(e_load));
            check("dly_data",     int'(dly_data),     e_load ? m_seed : 0);
            check("dly_en",       int'(dly_en),       int'(e_en));
            check("result_ms",    int'(result_ms),    e_res);
            check("result_valid", int'(result_valid), int'(m_valid));
            check("too_early",    int'(too_early),    int'(m_early));
            check("timeout",      int'(timeout),      int'(m_tout));
`ifdef REACTION_BEST_EN
            check("best_ms",      int'(best_ms),      m_best);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (led !== 1'b1 && n < 2000) begin tick(); n++; end
        check("wait_led_bound", int'(n < 2000), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    // Full trial: stop coincident with the ms-th tick after the lamp.
    task automatic trial_stop(input int ms);
        int n;
        pulse_start();
        wait_led(n);
        repeat (ms * TD - 1) tick();
        pulse_stop();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] nl;

        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result_ms), 0);
        reset = 1'b0;
        tick();

        // Trial 1: seed 2, stop on the 17th ms tick
        n = 0;
        nl = lfsr_step(m_lfsr);
        while (nl[1:0] != 2'd2 && n < 300) begin tick(); n++; nl = lfsr_step(m_lfsr); end
        check("seed_search_bound", int'(n < 300), 1);
        pulse_start();
        check("t1_dly_data", int'(dly_data), 2);
        tick();
        wait_led(n);
        check("t1_wait_cycles", n, 120);
        repeat (17 * TD - 1) tick();
        pulse_stop();
        check("t1_result", int'(result_ms), 17);
        check("t1_valid", int'(result_valid), 1);
        check("t1_early", int'(too_early), 0);
        repeat (5) tick();

        // Trial 2: stop 5 cycles into WAIT
        pulse_start();
        tick();
        repeat (4) tick();
        pulse_stop();
        check("t2_early", int'(too_early), 1);
        check("t2_valid", int'(result_valid), 0);
        check("t2_led", int'(led), 0);
        // stop in IDLE/DONE is ignored
        pulse_stop();
        check("t2_stop_ignored", int'(busy), 0);

        // Trial 2b: stop during ARM
        pulse_start();
        pulse_stop();
        check("t2b_early", int'(too_early), 1);
        check("t2b_busy", int'(busy), 0);

        // Trial 3: no stop -> timeout; start while busy ignored
        pulse_start();
        wait_led(n);
        pulse_start();
        n = 1;
        while (busy && n < 1000) begin tick(); n++; end
        check("t3_go_cycles", n, 200);
        check("t3_timeout", int'(timeout), 1);
        check("t3_result", int'(result_ms), 50);
        check("t3_valid", int'(result_valid), 0);

        // Trial 4: stop coincident with the 50th tick
        trial_stop(50);
        check("t4_result", int'(result_ms), 50);
        check("t4_valid", int'(result_valid), 1);
        check("t4_timeout", int'(timeout), 0);

        // Trial 5: reset during GO
        pulse_start();
        wait_led(n);
        repeat (10) tick();
        check("t5_pre_result", int'(result_ms), 2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_led", int'(led), 0);
        check("t5_result", int'(result_ms), 0);
        check("t5_busy", int'(busy), 0);
        tick();

`ifdef REACTION_BEST_EN
        check("t6_best_reset", int'(best_ms), 16383);
        trial_stop(30);
        tick();
        check("t6_best_30", int'(best_ms), 30);
        trial_stop(12);
        pulse_start(); tick(); tick(); pulse_stop();
        trial_stop(20);
        tick();
        check("t6_best_final", int'(best_ms), 12);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
